// File: rtl/hdr_dispatcher_if.sv
// Command/engine handshake bundle between the I3C engine, the HDR dispatcher
// and the CCC / per-mode engines.
interface hdr_dispatcher_if #(
  parameter int N_MODES = 4,
  parameter int MODE_W  = 3
);
  logic               i_en;
  logic               i_toc;
  logic               i_cp;
  logic [MODE_W-1:0]  i_mode;
  logic               i_ccc_done;
  logic [N_MODES-1:0] i_mode_done;
  logic               o_ccc_en;
  logic [N_MODES-1:0] o_mode_en;
  logic               o_busy;
  logic               o_done;
  logic               o_exit;
  logic               o_err;
  logic [1:0]         o_err_code;

  modport master (
    output i_en, i_toc, i_cp, i_mode, i_ccc_done, i_mode_done,
    input  o_ccc_en, o_mode_en, o_busy, o_done, o_exit, o_err, o_err_code
  );

  modport slave (
    input  i_en, i_toc, i_cp, i_mode, i_ccc_done, i_mode_done,
    output o_ccc_en, o_mode_en, o_busy, o_done, o_exit, o_err, o_err_code
  );
endinterface

// File: rtl/hdr_dispatcher.sv
// HDR command dispatcher: sequences an optional CCC phase and one HDR mode
// engine per command, with a per-phase watchdog and abort on request drop.
module hdr_dispatcher #(
  parameter int N_MODES = 4,
  parameter int MODE_W  = 3,
  parameter int TMO_CYC = 1024
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  hdr_dispatcher_if.slave  io_hdr
);
  localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {IDLE, CCC, MODE, DONE, ERR} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_en_q;
  logic               r_toc;
  logic [MODE_W-1:0]  r_mode;
  logic               r_ccc_en;
  logic [N_MODES-1:0] r_mode_en;
  logic               r_busy;
  logic               r_done;
  logic               r_exit;
  logic               r_err;
  logic [1:0]         r_err_code;

  logic w_rise;
  logic w_mode_ok;
  logic w_hit;
  logic w_tmo;

  function automatic logic [N_MODES-1:0] onehot(input logic [MODE_W-1:0] m);
    onehot = N_MODES'(1) << m;
  endfunction

  assign w_rise    = io_hdr.i_en & ~r_en_q;
  assign w_mode_ok = (int'(io_hdr.i_mode) < N_MODES);
  // r_mode_en is the one-hot of the latched mode while in MODE, so it masks
  // out completion pulses from every other engine.
  assign w_hit     = |(io_hdr.i_mode_done & r_mode_en);
  assign w_tmo     = (r_cnt == TMO_LAST);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_en_q     <= 1'b0;
      r_toc      <= 1'b0;
      r_mode     <= '0;
      r_ccc_en   <= 1'b0;
      r_mode_en  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_exit     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_en_q <= io_hdr.i_en;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_exit <= 1'b0;
      unique case (r_state)
        IDLE: if (w_rise) begin
          r_toc  <= io_hdr.i_toc;
          r_mode <= io_hdr.i_mode;
          r_cnt  <= '0;
          if (!w_mode_ok) begin
            r_state    <= ERR;
            r_err      <= 1'b1;
            r_exit     <= 1'b1;
            r_err_code <= 2'b01;
          end else if (io_hdr.i_cp) begin
            r_state  <= CCC;
            r_ccc_en <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state   <= MODE;
            r_mode_en <= onehot(io_hdr.i_mode);
            r_busy    <= 1'b1;
          end
        end
        // Completion is checked first so it wins over abort and timeout.
        CCC: if (io_hdr.i_ccc_done) begin
          r_state   <= MODE;
          r_ccc_en  <= 1'b0;
          r_mode_en <= onehot(r_mode);
          r_cnt     <= '0;
        end else if (!io_hdr.i_en || w_tmo) begin
          r_state    <= ERR;
          r_ccc_en   <= 1'b0;
          r_busy     <= 1'b0;
          r_err      <= 1'b1;
          r_exit     <= 1'b1;
          r_err_code <= io_hdr.i_en ? 2'b10 : 2'b00;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        MODE: if (w_hit) begin
          r_state   <= DONE;
          r_mode_en <= '0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_exit    <= r_toc;
        end else if (!io_hdr.i_en || w_tmo) begin
          r_state    <= ERR;
          r_mode_en  <= '0;
          r_busy     <= 1'b0;
          r_err      <= 1'b1;
          r_exit     <= 1'b1;
          r_err_code <= io_hdr.i_en ? 2'b11 : 2'b00;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_hdr.o_ccc_en   = r_ccc_en;
  assign io_hdr.o_mode_en  = r_mode_en;
  assign io_hdr.o_busy     = r_busy;
  assign io_hdr.o_done     = r_done;
  assign io_hdr.o_exit     = r_exit;
  assign io_hdr.o_err      = r_err;
  assign io_hdr.o_err_code = r_err_code;
endmodule

// File: tb/tb_hdr_dispatcher.sv
// Bench for hdr_dispatcher: directed scenarios plus random commands checked
// against a per-command outcome model.
module tb_hdr_dispatcher;
  localparam int NM  = 4;
  localparam int MW  = 3;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hdr_dispatcher_if #(.N_MODES(NM), .MODE_W(MW)) bus();

  hdr_dispatcher #(.N_MODES(NM), .MODE_W(MW), .TMO_CYC(TMO)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .io_hdr    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_code = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One phase: ends at the earliest of done (d), abort (ar), watchdog (TMO);
  // ties go done > abort > timeout. kind: 0 done, 1 abort, 2 timeout.
  function automatic void ph(input int d, input int ar, output int len, output int kind);
    len = TMO; kind = 2;
    if (ar >= 1 && ar <= len) begin len = ar; kind = 1; end
    if (d >= 1 && d <= len) begin len = d; kind = 0; end
  endfunction

  // dc/dm: enabled-cycle on which the engine pulses done (0 = never);
  // a: command cycle on which i_en drops and stays low (0 = never).
  function automatic void model(input bit cp, input int mode, input int dc, input int dm,
                                input int a, output int ec, output int em,
                                output bit edone, output logic [1:0] ecode);
    int k, ar;
    ec = 0; em = 0; edone = 0; ecode = 2'b01;
    if (mode >= NM) return;
    if (cp) begin
      ph(dc, a, ec, k);
      if (k != 0) begin ecode = (k == 1) ? 2'b00 : 2'b10; return; end
    end
    ar = (a == 0) ? 0 : ((a > ec) ? a - ec : 1);
    ph(dm, ar, em, k);
    if (k == 0) edone = 1;
    else ecode = (k == 1) ? 2'b00 : 2'b11;
  endfunction

  task automatic run_cmd(input bit cp, input int mode, input bit toc, input int dc,
                         input int dm, input int a, input bit hold);
    int ec, em, n_ccc, n_mode, n_wrong, n_ovl, n_busy, n_done, n_err, cc, mc, n, tail;
    bit edone, valid, hit;
    logic [1:0] ecode, got_code;
    logic got_exit;
    logic [NM-1:0] tgt;
    n_ccc = 0; n_mode = 0; n_wrong = 0; n_ovl = 0; n_busy = 0; n_done = 0; n_err = 0;
    cc = 0; mc = 0; n = 0; tail = -1; got_exit = 1'b0; got_code = 2'b00;
    model(cp, mode, dc, dm, a, ec, em, edone, ecode);
    valid = (mode < NM);
    tgt = valid ? (NM'(1) << mode) : '0;
    @(negedge clk);
    bus.i_cp = cp; bus.i_toc = toc; bus.i_mode = MW'(mode); bus.i_en = 1'b1;
    while (tail != 0 && n < 2*TMO + 8) begin
      @(negedge clk);
      n++;
      if (tail > 0) tail--;
      if (bus.o_ccc_en) n_ccc++;
      if (valid && bus.o_mode_en == tgt) n_mode++;
      else if (bus.o_mode_en != '0) n_wrong++;
      if (bus.o_ccc_en && bus.o_mode_en != '0) n_ovl++;
      if (bus.o_busy) n_busy++;
      if (bus.o_done) begin n_done++; got_exit = bus.o_exit; if (tail < 0) tail = 1; end
      if (bus.o_err) begin
        n_err++; got_exit = bus.o_exit; got_code = bus.o_err_code;
        if (tail < 0) tail = 1;
      end
      // engines respond to their own enable; everything else is noise
      if (bus.o_ccc_en) cc++;
      bus.i_ccc_done = bus.o_ccc_en ? (cc == dc) : 1'($urandom_range(0, 1));
      hit = |(bus.o_mode_en & tgt);
      if (hit) mc++;
      bus.i_mode_done = (NM'($urandom) & ~tgt) | ((hit && mc == dm) ? tgt : '0);
      if (n == a) bus.i_en = 1'b0;
    end
    chk("finished", tail == 0, 1);
    chk("ccc_cycles", n_ccc, ec);
    chk("mode_cycles", n_mode, em);
    chk("mode_wrong", n_wrong, 0);
    chk("overlap", n_ovl, 0);
    chk("busy_cycles", n_busy, ec + em);
    chk("done_pulses", n_done, edone);
    chk("err_pulses", n_err, !edone);
    chk("exit", got_exit, edone ? toc : 1'b1);
    if (!edone) begin
      exp_code = ecode;
      chk("err_code", got_code, ecode);
    end
    chk("code_held", bus.o_err_code, exp_code);
    if (!hold) bus.i_en = 1'b0;
    bus.i_ccc_done = 1'b0;
    bus.i_mode_done = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int idle_act, pulses;
    bus.i_en = 1'b0; bus.i_toc = 1'b0; bus.i_cp = 1'b0; bus.i_mode = '0;
    bus.i_ccc_done = 1'b0; bus.i_mode_done = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ccc_en", bus.o_ccc_en, 0);
    chk("rst_mode_en", bus.o_mode_en, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_exit", bus.o_exit, 0);
    chk("rst_code", bus.o_err_code, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(0, 2, 1, 0, 5, 0, 0);   // plain mode transfer, exit
    run_cmd(1, 1, 0, 3, 4, 0, 0);   // CCC then mode, restart
    run_cmd(0, 6, 1, 0, 0, 0, 0);   // invalid mode
    run_cmd(1, 3, 1, 0, 0, 0, 0);   // CCC timeout
    run_cmd(0, 0, 1, 0, 0, 0, 0);   // mode timeout
    run_cmd(0, 3, 0, 0, 8, 0, 0);   // done on final watchdog cycle
    run_cmd(1, 2, 1, 4, 0, 4, 0);   // CCC done beats abort, abort in MODE
    run_cmd(0, 1, 1, 0, 0, 3, 0);   // abort mid-MODE

    // request held high after DONE must not start a new command
    run_cmd(0, 2, 0, 0, 2, 0, 1);
    idle_act = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_ccc_en || bus.o_mode_en != '0 || bus.o_done || bus.o_err)
        idle_act++;
    end
    chk("held_en_idle", idle_act, 0);
    bus.i_en = 1'b0;
    @(negedge clk);

    // timeout first so the reset below must clear a nonzero code
    run_cmd(0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus.i_cp = 1'b1; bus.i_mode = MW'(1); bus.i_toc = 1'b1; bus.i_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_ccc", bus.o_ccc_en, 1);
    rst = 1'b1;
    bus.i_en = 1'b0;
    #1;
    chk("mid_rst_ccc", bus.o_ccc_en, 0);
    chk("mid_rst_busy", bus.o_busy, 0);
    #1 rst = 1'b0;
    exp_code = 2'b00;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done || bus.o_err || bus.o_ccc_en) pulses++;
    end
    chk("post_rst_quiet", pulses, 0);
    chk("post_rst_code", bus.o_err_code, 0);
    run_cmd(1, 0, 1, 2, 3, 0, 0);

    for (int i = 0; i < 200; i++) begin
      int m, dc, dm, a;
      m  = ($urandom_range(0, 3) == 0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
      dc = $urandom_range(0, TMO + 2);
      dm = $urandom_range(0, TMO + 2);
      a  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2*TMO + 2) : 0;
      run_cmd(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)), dc, dm, a, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
